// File: rtl/inst_decode_stage_pkg.sv
// Shared constants for the instruction-decode stage: widths, MIPS opcodes/functs, ALU encodings.
package inst_decode_stage_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_AW_DEF = 5;

    // Primary opcodes (ir[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (ir[5:0])
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_LUI = 4'd9
    } alu_op_e;

endpackage

// File: rtl/inst_decode_stage_reg_file.sv
// 2^REG_AW x DATA_W register file: two async read ports, one sync write port, r0 hard zero, write bypass.
module reg_file_32x32
    import inst_decode_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int unsigned NUM_REGS = 1 << REG_AW;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Next-state: single write, r0 never written
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    // Array update; reset clears every register
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port A: r0 reads zero, same-cycle write forwarded
    always_comb begin
        rdata_a = regs_q[raddr_a];
        if (raddr_a == '0) begin
            rdata_a = '0;
        end else if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
    end

    // Read port B: same behaviour as port A
    always_comb begin
        rdata_b = regs_q[raddr_b];
        if (raddr_b == '0) begin
            rdata_b = '0;
        end else if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: rtl/inst_decode_stage.sv
// Instruction-decode stage: IF/ID register, MIPS field split, operand read and control decode.
module inst_decode_stage
    import inst_decode_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Instruct_code,
    input  logic              instr_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_valid,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] imm_ext,
    output logic [4:0]        shamt,
    output logic [REG_AW-1:0] dest_addr,
    output logic [3:0]        alu_op,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              branch_eq,
    output logic              branch_ne,
    output logic              jump,
    output logic              illegal
);

    logic [31:0] ir_q, ir_d;
    logic        v_q, v_d;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_f, rt_f, rd_f;
    logic [15:0] imm16;

    alu_op_e     alu_op_c;
    logic [REG_AW-1:0] dest_c;
    logic        reg_write_c, mem_read_c, mem_write_c;
    logic        branch_eq_c, branch_ne_c, jump_c, illegal_c;
    logic        ext_zero, ext_lui;

    // IF/ID next state: flush beats stall beats load
    always_comb begin
        ir_d = ir_q;
        v_d  = v_q;
        if (flush) begin
            v_d = 1'b0;
        end else if (!stall) begin
            ir_d = Instruct_code;
            v_d  = instr_valid;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q <= '0;
            v_q  <= 1'b0;
        end else begin
            ir_q <= ir_d;
            v_q  <= v_d;
        end
    end

    // Field split
    always_comb begin
        opcode = ir_q[31:26];
        rs_f   = ir_q[25:21];
        rt_f   = ir_q[20:16];
        rd_f   = ir_q[15:11];
        shamt  = ir_q[10:6];
        funct  = ir_q[5:0];
        imm16  = ir_q[15:0];
    end

    reg_file_32x32 #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (REG_AW'(rs_f)),
        .rdata_a (rs_data),
        .raddr_b (REG_AW'(rt_f)),
        .rdata_b (rt_data)
    );

    // Control decode; flags gated by the valid bit
    always_comb begin
        alu_op_c    = ALU_ADD;
        dest_c      = '0;
        reg_write_c = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        branch_eq_c = 1'b0;
        branch_ne_c = 1'b0;
        jump_c      = 1'b0;
        illegal_c   = 1'b0;
        ext_zero    = 1'b0;
        ext_lui     = 1'b0;

        unique case (opcode)
            OP_RTYPE: begin
                reg_write_c = 1'b1;
                dest_c      = REG_AW'(rd_f);
                case (funct)
                    FN_ADD:  alu_op_c = ALU_ADD;
                    FN_SUB:  alu_op_c = ALU_SUB;
                    FN_AND:  alu_op_c = ALU_AND;
                    FN_OR:   alu_op_c = ALU_OR;
                    FN_XOR:  alu_op_c = ALU_XOR;
                    FN_NOR:  alu_op_c = ALU_NOR;
                    FN_SLT:  alu_op_c = ALU_SLT;
                    FN_SLL:  alu_op_c = ALU_SLL;
                    FN_SRL:  alu_op_c = ALU_SRL;
                    default: begin
                        illegal_c   = 1'b1;
                        reg_write_c = 1'b0;
                        dest_c      = '0;
                    end
                endcase
            end
            OP_ADDI: begin
                alu_op_c = ALU_ADD; reg_write_c = 1'b1; dest_c = REG_AW'(rt_f);
            end
            OP_SLTI: begin
                alu_op_c = ALU_SLT; reg_write_c = 1'b1; dest_c = REG_AW'(rt_f);
            end
            OP_ANDI: begin
                alu_op_c = ALU_AND; reg_write_c = 1'b1; dest_c = REG_AW'(rt_f); ext_zero = 1'b1;
            end
            OP_ORI: begin
                alu_op_c = ALU_OR; reg_write_c = 1'b1; dest_c = REG_AW'(rt_f); ext_zero = 1'b1;
            end
            OP_XORI: begin
                alu_op_c = ALU_XOR; reg_write_c = 1'b1; dest_c = REG_AW'(rt_f); ext_zero = 1'b1;
            end
            OP_LUI: begin
                alu_op_c = ALU_LUI; reg_write_c = 1'b1; dest_c = REG_AW'(rt_f); ext_lui = 1'b1;
            end
            OP_LW: begin
                alu_op_c = ALU_ADD; mem_read_c = 1'b1; reg_write_c = 1'b1; dest_c = REG_AW'(rt_f);
            end
            OP_SW: begin
                alu_op_c = ALU_ADD; mem_write_c = 1'b1;
            end
            OP_BEQ: begin
                alu_op_c = ALU_SUB; branch_eq_c = 1'b1;
            end
            OP_BNE: begin
                alu_op_c = ALU_SUB; branch_ne_c = 1'b1;
            end
            OP_J: begin
                jump_c = 1'b1;
            end
            default: begin
                illegal_c = 1'b1;
            end
        endcase

        if (!v_q) begin
            reg_write_c = 1'b0;
            mem_read_c  = 1'b0;
            mem_write_c = 1'b0;
            branch_eq_c = 1'b0;
            branch_ne_c = 1'b0;
            jump_c      = 1'b0;
            illegal_c   = 1'b0;
        end
    end

    // Immediate extension: lui shifts up, logical ops zero-extend, rest sign-extend
    always_comb begin
        if (ext_lui) begin
            imm_ext = DATA_W'({imm16, 16'h0000});
        end else if (ext_zero) begin
            imm_ext = {{(DATA_W-16){1'b0}}, imm16};
        end else begin
            imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
        end
    end

    // Output drive
    always_comb begin
        id_valid  = v_q;
        dest_addr = dest_c;
        alu_op    = alu_op_c;
        reg_write = reg_write_c;
        mem_read  = mem_read_c;
        mem_write = mem_write_c;
        branch_eq = branch_eq_c;
        branch_ne = branch_ne_c;
        jump      = jump_c;
        illegal   = illegal_c;
    end

endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed bench for inst_decode_stage: decode vector table plus pipeline/bypass sequences.
module tb_inst_decode_stage;

    logic        clk;
    logic        reset;
    logic [31:0] Instruct_code;
    logic        instr_valid;
    logic        stall;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        id_valid;
    logic [31:0] rs_data, rt_data, imm_ext;
    logic [4:0]  shamt;
    logic [4:0]  dest_addr;
    logic [3:0]  alu_op;
    logic        reg_write, mem_read, mem_write, branch_eq, branch_ne, jump, illegal;

    int n_tests = 0;
    int n_fail  = 0;

    inst_decode_stage dut (
        .clk           (clk),
        .reset         (reset),
        .Instruct_code (Instruct_code),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .flush         (flush),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .id_valid      (id_valid),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .imm_ext       (imm_ext),
        .shamt         (shamt),
        .dest_addr     (dest_addr),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .branch_eq     (branch_eq),
        .branch_ne     (branch_ne),
        .jump          (jump),
        .illegal       (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags packed as {reg_write, mem_read, mem_write, branch_eq, branch_ne, jump}
    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        exp_valid;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
        logic [31:0] exp_imm;
        logic [4:0]  exp_shamt;
        logic [4:0]  exp_dest;
        logic        chk_alu;
        logic [3:0]  exp_alu;
        logic [5:0]  exp_flags;
        logic        exp_illegal;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] flags();
        return {reg_write, mem_read, mem_write, branch_eq, branch_ne, jump};
    endfunction

    initial begin
        // r5 holds 0x1234, every other register 0 while the table runs
        vecs[0]  = '{32'h00A51820, 1'b1, 1'b1, 32'h1234, 32'h1234, 32'h00001820, 5'd0,  5'd3, 1'b1, 4'd0, 6'b100000, 1'b0}; // add r3,r5,r5
        vecs[1]  = '{32'h2002FFFF, 1'b1, 1'b1, 32'h0,    32'h0,    32'hFFFFFFFF, 5'd31, 5'd2, 1'b1, 4'd0, 6'b100000, 1'b0}; // addi r2,r0,-1
        vecs[2]  = '{32'h3402FFFF, 1'b1, 1'b1, 32'h0,    32'h0,    32'h0000FFFF, 5'd31, 5'd2, 1'b1, 4'd3, 6'b100000, 1'b0}; // ori r2,r0,0xFFFF
        vecs[3]  = '{32'h3C041234, 1'b1, 1'b1, 32'h0,    32'h0,    32'h12340000, 5'd8,  5'd4, 1'b1, 4'd9, 6'b100000, 1'b0}; // lui r4,0x1234
        vecs[4]  = '{32'h8CA60008, 1'b1, 1'b1, 32'h1234, 32'h0,    32'h00000008, 5'd0,  5'd6, 1'b1, 4'd0, 6'b110000, 1'b0}; // lw r6,8(r5)
        vecs[5]  = '{32'hAC05FFFC, 1'b1, 1'b1, 32'h0,    32'h1234, 32'hFFFFFFFC, 5'd31, 5'd0, 1'b1, 4'd0, 6'b001000, 1'b0}; // sw r5,-4(r0)
        vecs[6]  = '{32'h10A0FFFE, 1'b1, 1'b1, 32'h1234, 32'h0,    32'hFFFFFFFE, 5'd31, 5'd0, 1'b1, 4'd1, 6'b000100, 1'b0}; // beq r5,r0,-2
        vecs[7]  = '{32'h14A0FFFE, 1'b1, 1'b1, 32'h1234, 32'h0,    32'hFFFFFFFE, 5'd31, 5'd0, 1'b1, 4'd1, 6'b000010, 1'b0}; // bne r5,r0,-2
        vecs[8]  = '{32'h08000010, 1'b1, 1'b1, 32'h0,    32'h0,    32'h00000010, 5'd0,  5'd0, 1'b0, 4'd0, 6'b000001, 1'b0}; // j 0x10
        vecs[9]  = '{32'h00051900, 1'b1, 1'b1, 32'h0,    32'h1234, 32'h00001900, 5'd4,  5'd3, 1'b1, 4'd7, 6'b100000, 1'b0}; // sll r3,r5,4
        vecs[10] = '{32'h00A0082A, 1'b1, 1'b1, 32'h1234, 32'h0,    32'h0000082A, 5'd0,  5'd1, 1'b1, 4'd6, 6'b100000, 1'b0}; // slt r1,r5,r0
        vecs[11] = '{32'h30A28000, 1'b1, 1'b1, 32'h1234, 32'h0,    32'h00008000, 5'd0,  5'd2, 1'b1, 4'd2, 6'b100000, 1'b0}; // andi r2,r5,0x8000
        vecs[12] = '{32'hFC000000, 1'b1, 1'b1, 32'h0,    32'h0,    32'h00000000, 5'd0,  5'd0, 1'b0, 4'd0, 6'b000000, 1'b1}; // opcode 0x3F
        vecs[13] = '{32'hFC000000, 1'b0, 1'b0, 32'h0,    32'h0,    32'h00000000, 5'd0,  5'd0, 1'b0, 4'd0, 6'b000000, 1'b0}; // 0x3F, not valid
        vecs[14] = '{32'h00000001, 1'b1, 1'b1, 32'h0,    32'h0,    32'h00000001, 5'd0,  5'd0, 1'b0, 4'd0, 6'b000000, 1'b1}; // bad funct

        reset = 1'b1; Instruct_code = '0; instr_valid = 1'b0;
        stall = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state: ir=0 decodes as sll but nothing is valid
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_flags",    32'(flags()),  32'd0);
        check("rst_illegal",  32'(illegal),  32'd0);
        check("rst_alu_op",   32'(alu_op),   32'd7);
        check("rst_dest",     32'(dest_addr), 32'd0);

        // Registers read zero after reset
        Instruct_code = 32'h00A51820; instr_valid = 1'b1;
        tick();
        check("rst_rs_r5", rs_data, 32'h0);
        check("rst_rt_r5", rt_data, 32'h0);

        // Write r5 = 0x1234
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
        tick();
        wb_en = 1'b0;

        // Decode table
        for (int i = 0; i < 15; i++) begin
            Instruct_code = vecs[i].instr;
            instr_valid   = vecs[i].valid;
            tick();
            check($sformatf("v%0d_id_valid", i), 32'(id_valid),  32'(vecs[i].exp_valid));
            check($sformatf("v%0d_rs", i),       rs_data,         vecs[i].exp_rs);
            check($sformatf("v%0d_rt", i),       rt_data,         vecs[i].exp_rt);
            check($sformatf("v%0d_imm", i),      imm_ext,         vecs[i].exp_imm);
            check($sformatf("v%0d_shamt", i),    32'(shamt),      32'(vecs[i].exp_shamt));
            check($sformatf("v%0d_dest", i),     32'(dest_addr),  32'(vecs[i].exp_dest));
            if (vecs[i].chk_alu)
                check($sformatf("v%0d_alu", i),  32'(alu_op),     32'(vecs[i].exp_alu));
            check($sformatf("v%0d_flags", i),    32'(flags()),    32'(vecs[i].exp_flags));
            check($sformatf("v%0d_illegal", i),  32'(illegal),    32'(vecs[i].exp_illegal));
        end

        // Bypass: decode add r1,r7,r0, then write r7 in the same cycle
        Instruct_code = 32'h00E00820; instr_valid = 1'b1;
        tick();
        check("byp_before", rs_data, 32'h0);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
        #1;
        check("byp_same_cycle", rs_data, 32'hDEADBEEF);
        tick();
        wb_en = 1'b0;
        #1;
        check("byp_from_array", rs_data, 32'hDEADBEEF);

        // Write to r0 is ignored, even via bypass
        Instruct_code = 32'h00000820; // add r1,r0,r0
        tick();
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        #1;
        check("r0_bypass", rs_data, 32'h0);
        tick();
        wb_en = 1'b0;
        #1;
        check("r0_array", rt_data, 32'h0);

        // Stall holds ir for 3 cycles while fetch keeps changing
        Instruct_code = 32'h00A51820; instr_valid = 1'b1;
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            Instruct_code = 32'hAC05FFFC + 32'(k);
            instr_valid   = 1'(k & 1);
            tick();
            check($sformatf("stall%0d_valid", k), 32'(id_valid),  32'd1);
            check($sformatf("stall%0d_dest", k),  32'(dest_addr), 32'd3);
            check($sformatf("stall%0d_rs", k),    rs_data,        32'h1234);
            check($sformatf("stall%0d_mw", k),    32'(mem_write), 32'd0);
        end

        // Flush together with stall: flush wins
        flush = 1'b1;
        tick();
        check("flush_stall_valid", 32'(id_valid),  32'd0);
        check("flush_stall_flags", 32'(flags()),   32'd0);
        check("flush_ir_kept",     32'(dest_addr), 32'd3);
        flush = 1'b0; stall = 1'b0;

        // Reset asserted during a stall clears v and the register file
        Instruct_code = 32'h00A51820; instr_valid = 1'b1;
        tick();
        check("pre_rst_valid", 32'(id_valid), 32'd1);
        stall = 1'b1; reset = 1'b1;
        tick();
        check("rst_stall_valid", 32'(id_valid), 32'd0);
        reset = 1'b0; stall = 1'b0;
        tick();
        check("post_rst_valid", 32'(id_valid), 32'd1);
        check("post_rst_r5",    rs_data,       32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
